// File: rtl/ef_pwm_multi.sv
// Multi-channel PWM generator: one shared up or up/down period counter with prescaler,
// per-channel shadowed compare, 4-event action table, polarity invert and dead-time pair.
module ef_pwm_multi #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cntr_mode,
  input  logic [7:0]                prescale,
  input  logic [WIDTH-1:0]          top,
  input  logic [CHANNELS*WIDTH-1:0] cmp,
  input  logic [CHANNELS*8-1:0]     act,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS-1:0]       inv,
  input  logic [DT_WIDTH-1:0]       dt,
  output logic [CHANNELS-1:0]       pwm,
  output logic [CHANNELS-1:0]       pwm_n,
  output logic                      period_irq
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dirT;

  logic [7:0]          psc;
  logic [WIDTH-1:0]    cnt, cntNext, topS;
  logic [WIDTH-1:0]    cmpS [CHANNELS];
  dirT                 dir, dirNext;
  logic [CHANNELS-1:0] r, rNext, dtcZero;
  logic [DT_WIDTH-1:0] dtc [CHANNELS];
  logic                tick, atTop, atZero, boundary;

  assign tick     = en && (psc == prescale);
  assign atTop    = (cnt == topS);
  assign atZero   = (cnt == '0);
  assign boundary = tick && (cntr_mode ? (dir == DIR_DOWN && atZero) : atTop);

  // With a zero top in triangle mode the direction still flips so the period boundary keeps firing.
  always_comb begin
    cntNext = cnt;
    dirNext = dir;
    if (!cntr_mode) begin
      dirNext = DIR_UP;
      cntNext = atTop ? '0 : cnt + WIDTH'(1);
    end else if (topS == '0) begin
      cntNext = '0;
      dirNext = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
    end else if (dir == DIR_UP && atTop) begin
      dirNext = DIR_DOWN;
      cntNext = topS - WIDTH'(1);
    end else if (dir == DIR_DOWN && atZero) begin
      dirNext = DIR_UP;
      cntNext = WIDTH'(1);
    end else if (dir == DIR_UP) begin
      cntNext = cnt + WIDTH'(1);
    end else begin
      cntNext = cnt - WIDTH'(1);
    end
  end

  // Highest-priority event carrying a non-zero action wins: TOP > CMPD > CMPU > ZERO.
  always_comb begin
    rNext   = r;
    dtcZero = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      logic       cmpHit;
      logic [1:0] sel;
      cmpHit     = (cnt == cmpS[i]);
      sel        = 2'b00;
      dtcZero[i] = (dtc[i] == '0);
      if (atTop && act[i*8+6 +: 2] != 2'b00)
        sel = act[i*8+6 +: 2];
      else if (cmpHit && cntr_mode && dir == DIR_DOWN && act[i*8+4 +: 2] != 2'b00)
        sel = act[i*8+4 +: 2];
      else if (cmpHit && dir == DIR_UP && act[i*8+2 +: 2] != 2'b00)
        sel = act[i*8+2 +: 2];
      else if (atZero && act[i*8 +: 2] != 2'b00)
        sel = act[i*8 +: 2];
      if (tick) begin
        case (sel)
          2'd1:    rNext[i] = 1'b0;
          2'd2:    rNext[i] = 1'b1;
          2'd3:    rNext[i] = ~r[i];
          default: rNext[i] = r[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc        <= '0;
      cnt        <= '0;
      dir        <= DIR_UP;
      topS       <= '0;
      r          <= '0;
      period_irq <= 1'b0;
      pwm        <= '0;
      pwm_n      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cmpS[i] <= '0;
        dtc[i]  <= '0;
      end
    end else if (!en) begin
      // Idle: shadows track the live registers so the first enabled period uses them.
      psc        <= '0;
      cnt        <= '0;
      dir        <= DIR_UP;
      topS       <= top;
      r          <= '0;
      period_irq <= 1'b0;
      pwm        <= inv;
      pwm_n      <= inv;
      for (int i = 0; i < CHANNELS; i++) begin
        cmpS[i] <= cmp[i*WIDTH +: WIDTH];
        dtc[i]  <= '0;
      end
    end else begin
      psc <= tick ? 8'd0 : psc + 8'd1;
      if (tick) begin
        cnt <= cntNext;
        dir <= dirNext;
      end
      if (boundary) begin
        topS <= top;
        for (int i = 0; i < CHANNELS; i++) cmpS[i] <= cmp[i*WIDTH +: WIDTH];
      end
      period_irq <= boundary;
      r          <= rNext;
      for (int i = 0; i < CHANNELS; i++) begin
        if (rNext[i] != r[i])
          dtc[i] <= dt;
        else if (!dtcZero[i])
          dtc[i] <= dtc[i] - DT_WIDTH'(1);
      end
      pwm   <= (r & dtcZero & ch_en) ^ inv;
      pwm_n <= (~r & dtcZero & ch_en) ^ inv;
    end
  end

endmodule

// File: tb/tb_ef_pwm_multi.sv
// Scoreboard bench for ef_pwm_multi: expected channel-0 pin segments and irq intervals are
// queued by the stimulus process and consumed by an independent monitor.
module tb_ef_pwm_multi;

  localparam int WIDTH = 32;
  localparam int CH    = 2;
  localparam int DTW   = 8;

  logic            clk, rst, en, cntrMode;
  logic [7:0]      prescale;
  logic [WIDTH-1:0] top;
  logic [CH*WIDTH-1:0] cmp;
  logic [CH*8-1:0] act;
  logic [CH-1:0]   chEn, inv;
  logic [DTW-1:0]  dt;
  logic [CH-1:0]   pwm, pwmN;
  logic            periodIrq;

  ef_pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CH), .DT_WIDTH(DTW)) dut (
    .clk(clk), .rst(rst), .en(en), .cntr_mode(cntrMode), .prescale(prescale),
    .top(top), .cmp(cmp), .act(act), .ch_en(chEn), .inv(inv), .dt(dt),
    .pwm(pwm), .pwm_n(pwmN), .period_irq(periodIrq)
  );

  typedef struct {
    logic [1:0] lv;
    int         len;
  } segT;

  segT   segQ[$];
  int    irqQ[$];
  int    checks = 0;
  int    passes = 0;
  int    armId  = 0;
  bit    monOn  = 0;
  string testName = "reset";

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  function automatic void checkOutput(string name, int actual, int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s/%s: got %0d, expected %0d", testName, name, actual, expected);
  endfunction

  // Reset, load config while disabled for one edge so shadows are valid, then enable and arm the monitor.
  task automatic applyStimulus(input string name, input logic mode, input logic [7:0] presc,
                               input logic [31:0] topV, input logic [31:0] cmp0,
                               input logic [7:0] act0, input logic [7:0] dtV, input logic [1:0] invV);
    @(negedge clk);
    testName = name;
    monOn    = 0;
    rst      = 1;
    en       = 0;
    cntrMode = mode;
    prescale = presc;
    top      = topV;
    cmp      = {32'd5, cmp0};
    act      = {8'h00, act0};
    chEn     = 2'b11;
    inv      = invV;
    dt       = dtV;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    en = 1;
    armId++;
    monOn = 1;
  endtask

  task automatic pushSeg(input logic [1:0] lv, input int len);
    segT s;
    s.lv  = lv;
    s.len = len;
    segQ.push_back(s);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (segQ.size() != 0 || irqQ.size() != 0); i++) @(posedge clk);
    checkOutput("pending expectations", segQ.size() + irqQ.size(), 0);
    segQ.delete();
    irqQ.delete();
    monOn = 0;
  endtask

  // Monitor: a pin segment is presented when {pwm[0],pwm_n[0]} changes; the partial first one is dropped.
  initial begin
    int         seenArm = 0;
    logic [1:0] curLv   = 2'b00;
    int         curLen  = 0;
    bit         firstSeg = 1;
    int         irqCnt  = 0;
    bit         irqSeen = 0;
    segT        s;
    forever begin
      @(negedge clk);
      #1;
      if (monOn) begin
        if (armId != seenArm) begin
          seenArm  = armId;
          curLv    = {pwm[0], pwmN[0]};
          curLen   = 1;
          firstSeg = 1;
          irqCnt   = 0;
          irqSeen  = 0;
        end else begin
          if ({pwm[0], pwmN[0]} == curLv) curLen++;
          else begin
            if (!firstSeg && segQ.size() > 0) begin
              s = segQ.pop_front();
              checkOutput("segment level", int'(curLv), int'(s.lv));
              checkOutput("segment length", curLen, s.len);
            end
            firstSeg = 0;
            curLv    = {pwm[0], pwmN[0]};
            curLen   = 1;
          end
          irqCnt++;
          if (periodIrq) begin
            if (irqSeen && irqQ.size() > 0) checkOutput("irq interval", irqCnt, irqQ.pop_front());
            irqSeen = 1;
            irqCnt  = 0;
          end
        end
      end
    end
  end

  initial begin
    rst = 1; en = 0; cntrMode = 0; prescale = 0; top = 0; cmp = 0; act = 0;
    chEn = 0; inv = 0; dt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset pwm", int'(pwm), 0);
    checkOutput("reset pwm_n", int'(pwmN), 0);
    checkOutput("reset irq", int'(periodIrq), 0);

    // Sawtooth, 3 high / 7 low, complementary with dt=0
    applyStimulus("up basic", 0, 8'd0, 32'd9, 32'd3, 8'h06, 8'd0, 2'b00);
    pushSeg(2'b01, 1); pushSeg(2'b10, 3); pushSeg(2'b01, 7);
    pushSeg(2'b10, 3); pushSeg(2'b01, 7); pushSeg(2'b10, 3);
    irqQ.push_back(10); irqQ.push_back(10);
    drain();
    @(negedge clk);
    chEn = 2'b10;
    @(posedge clk);
    @(negedge clk);
    checkOutput("ch_en off pins", int'({pwm[0], pwmN[0]}), 0);

    // Triangle with prescale 2: 24 clk period, 12 clk high
    applyStimulus("updown", 1, 8'd2, 32'd4, 32'd2, 8'h18, 8'd0, 2'b00);
    pushSeg(2'b01, 9); pushSeg(2'b10, 12); pushSeg(2'b01, 12); pushSeg(2'b10, 12);
    irqQ.push_back(24); irqQ.push_back(24);
    drain();

    // Dead time 2
    applyStimulus("deadtime", 0, 8'd0, 32'd9, 32'd3, 8'h06, 8'd2, 2'b00);
    pushSeg(2'b01, 1); pushSeg(2'b00, 2); pushSeg(2'b10, 1); pushSeg(2'b00, 2);
    pushSeg(2'b01, 5); pushSeg(2'b00, 2); pushSeg(2'b10, 1); pushSeg(2'b00, 2);
    pushSeg(2'b01, 5);
    irqQ.push_back(10);
    drain();

    applyStimulus("deadtime inv", 0, 8'd0, 32'd9, 32'd3, 8'h06, 8'd2, 2'b01);
    pushSeg(2'b10, 1); pushSeg(2'b11, 2); pushSeg(2'b01, 1); pushSeg(2'b11, 2);
    pushSeg(2'b10, 5); pushSeg(2'b11, 2); pushSeg(2'b01, 1);
    drain();

    // Compare written mid-period takes effect at the next boundary
    applyStimulus("cmp shadow", 0, 8'd0, 32'd9, 32'd3, 8'h06, 8'd0, 2'b00);
    pushSeg(2'b01, 1); pushSeg(2'b10, 3); pushSeg(2'b01, 7);
    pushSeg(2'b10, 6); pushSeg(2'b01, 4); pushSeg(2'b10, 6);
    irqQ.push_back(10); irqQ.push_back(10);
    repeat (5) @(posedge clk);
    @(negedge clk);
    cmp[31:0] = 32'd6;
    drain();

    applyStimulus("top shadow", 0, 8'd0, 32'd9, 32'd3, 8'h06, 8'd0, 2'b00);
    pushSeg(2'b01, 1); pushSeg(2'b10, 3); pushSeg(2'b01, 7);
    pushSeg(2'b10, 3); pushSeg(2'b01, 2); pushSeg(2'b10, 3); pushSeg(2'b01, 2);
    irqQ.push_back(5); irqQ.push_back(5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    top = 32'd4;
    drain();

    // Priority: CMPU beats ZERO, TOP beats CMPU
    applyStimulus("prio cmpu>zero", 0, 8'd0, 32'd9, 32'd0, 8'h06, 8'd0, 2'b00);
    repeat (25) @(negedge clk);
    checkOutput("pins", int'({pwm[0], pwmN[0]}), 1);
    drain();
    applyStimulus("prio top>cmpu", 0, 8'd0, 32'd9, 32'd9, 8'h48, 8'd0, 2'b00);
    repeat (25) @(negedge clk);
    checkOutput("pins", int'({pwm[0], pwmN[0]}), 1);
    drain();

    // Reset mid-period
    applyStimulus("mid reset", 0, 8'd0, 32'd9, 32'd3, 8'h06, 8'd0, 2'b00);
    monOn = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("pwm before rst", int'(pwm[0]), 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("pwm after rst", int'(pwm), 0);
    checkOutput("pwm_n after rst", int'(pwmN), 0);
    checkOutput("irq after rst", int'(periodIrq), 0);
    rst = 0;
    en  = 0;

    // Enable drop with ch0 inverted, then restart from zero
    applyStimulus("en drop", 0, 8'd0, 32'd9, 32'd3, 8'h06, 8'd0, 2'b01);
    monOn = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("pwm before drop", int'(pwm[0]), 0);
    en = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("pwm after drop", int'(pwm), 1);
    checkOutput("pwm_n after drop", int'(pwmN), 1);
    en = 1;
    armId++;
    monOn = 1;
    pushSeg(2'b10, 1); pushSeg(2'b01, 3); pushSeg(2'b10, 7); pushSeg(2'b01, 3);
    irqQ.push_back(10);
    drain();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
